// File: rtl/systolic_skew_feeder_if.sv
// Load/stream bundle between a matrix source, the skew feeder and the systolic array.
// master = matrix source and array side, slave = feeder.
interface systolic_skew_feeder_if #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned VEC_W = SIZE * DATA_WIDTH;

  logic             load_valid;
  logic             load_ready;
  logic [VEC_W-1:0] load_a_col;
  logic [VEC_W-1:0] load_b_row;
  logic [VEC_W-1:0] a_out;
  logic [VEC_W-1:0] b_out;
  logic             out_valid;
  logic             arr_rst_n;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_a_col, load_b_row,
    input  load_ready, a_out, b_out, out_valid, arr_rst_n, busy, done
  );

  modport slave (
    input  load_valid, load_a_col, load_b_row,
    output load_ready, a_out, b_out, out_valid, arr_rst_n, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Buffers A (by column) and B (by row), then replays them diagonally skewed into the array.
// Define SKEW_FEEDER_DBUF_EN for ping/pong banks so the next job loads while one streams.
module systolic_skew_feeder #(
  parameter int unsigned SIZE         = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FLUSH_CYCLES = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
);
  localparam int unsigned VEC_W = SIZE * DATA_WIDTH;
`ifdef SKEW_FEEDER_DBUF_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned K_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned T_W = $clog2(2 * SIZE);
  localparam int unsigned F_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SIZE - 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(2 * SIZE - 2);
  localparam logic [F_W-1:0] F_LAST = F_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, STREAM, FLUSH, DONE} state_t;

  state_t           state;
  logic [K_W-1:0]   kcnt;
  logic [T_W-1:0]   t;
  logic [F_W-1:0]   fcnt;
  logic [NB-1:0]    full;
  logic [NB-1:0]    full_nxt;
  logic             wr_sel, rd_sel, wr_nxt, rd_nxt;
  logic             accept, last_beat;
  logic [T_W-1:0]   t_sel;
  logic [VEC_W-1:0] skew_a, skew_b;
  logic [VEC_W-1:0] a_bank [NB][SIZE];
  logic [VEC_W-1:0] b_bank [NB][SIZE];

  // Bank bookkeeping: a bank is full from its last load beat until its job reaches DONE.
  always_comb begin
    accept    = bus.load_valid && bus.load_ready;
    last_beat = accept && (kcnt == K_LAST);
    full_nxt  = full;
    if (state == DONE) full_nxt[rd_sel] = 1'b0;
    if (last_beat)     full_nxt[wr_sel] = 1'b1;
    wr_nxt = (NB > 1 && last_beat) ? ~wr_sel : wr_sel;
    rd_nxt = (NB > 1) ? ~rd_sel : rd_sel;
  end

  // Skewed lane vectors for the beat about to be presented (t=0 while leaving CLEAR).
  always_comb begin
    t_sel  = (state == CLEAR) ? '0 : t + T_W'(1);
    skew_a = '0;
    skew_b = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (int'(t_sel) >= i && int'(t_sel) - i < int'(SIZE)) begin
        skew_a[i*DATA_WIDTH +: DATA_WIDTH] =
          a_bank[rd_sel][K_W'(int'(t_sel) - i)][i*DATA_WIDTH +: DATA_WIDTH];
        skew_b[i*DATA_WIDTH +: DATA_WIDTH] =
          b_bank[rd_sel][K_W'(int'(t_sel) - i)][i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Operand storage needs no reset: the full flags gate every read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_bank[wr_sel][kcnt] <= bus.load_a_col;
      b_bank[wr_sel][kcnt] <= bus.load_b_row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      kcnt           <= '0;
      t              <= '0;
      fcnt           <= '0;
      full           <= '0;
      wr_sel         <= 1'b0;
      rd_sel         <= 1'b0;
      bus.load_ready <= 1'b0;
      bus.a_out      <= '0;
      bus.b_out      <= '0;
      bus.out_valid  <= 1'b0;
      bus.arr_rst_n  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      full           <= full_nxt;
      wr_sel         <= wr_nxt;
      bus.load_ready <= ~full_nxt[wr_nxt];
      bus.done       <= 1'b0;
      if (accept) kcnt <= last_beat ? '0 : kcnt + K_W'(1);

      case (state)
        IDLE, LOAD: begin
          if (last_beat) begin
            state         <= CLEAR;
            rd_sel        <= wr_sel;
            bus.arr_rst_n <= 1'b0;
            bus.busy      <= 1'b1;
          end else begin
            bus.arr_rst_n <= 1'b1;
            if (accept) state <= LOAD;
          end
        end
        CLEAR: begin
          state         <= STREAM;
          t             <= '0;
          bus.arr_rst_n <= 1'b1;
          bus.out_valid <= 1'b1;
          bus.a_out     <= skew_a;
          bus.b_out     <= skew_b;
        end
        STREAM: begin
          if (t == T_LAST) begin
            state         <= FLUSH;
            fcnt          <= '0;
            bus.out_valid <= 1'b0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
          end else begin
            t         <= t + T_W'(1);
            bus.a_out <= skew_a;
            bus.b_out <= skew_b;
          end
        end
        FLUSH: begin
          if (fcnt == F_LAST) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            fcnt <= fcnt + F_W'(1);
          end
        end
        DONE: begin
          rd_sel <= rd_nxt;
          // A bank that filled while this job ran starts immediately.
          if (full_nxt[rd_nxt]) begin
            state         <= CLEAR;
            bus.arr_rst_n <= 1'b0;
            bus.busy      <= 1'b1;
          end else begin
            state <= (kcnt != '0 || accept) ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder: directed jobs, skew beats, timing and
// reconstructed array products. Covers the double-buffer path when SKEW_FEEDER_DBUF_EN is set.
module tb_systolic_skew_feeder;
  localparam int unsigned SIZE    = 8;
  localparam int unsigned DW      = 8;
  localparam int unsigned FLUSH   = 10;
  localparam int unsigned BEATS   = 2 * SIZE - 1;
  localparam int unsigned JOB_LAT = 1 + BEATS + FLUSH + 1;
  localparam int          TIMEOUT = 200;

  typedef logic [SIZE*DW-1:0] vec_t;
  typedef logic [SIZE-1:0][SIZE-1:0][DW-1:0] mat_t;
  typedef logic [SIZE-1:0][SIZE-1:0][31:0] cmat_t;
  typedef struct packed { vec_t a; vec_t b; } beat_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  beat_t  exp_q[$];
  longint done_q[$];
  longint clr_q[$];
  cmat_t  c_q[$];
  longint last_done = 0;

  vec_t   a_hist [BEATS];
  vec_t   b_hist [BEATS];
  int     bidx = 0;
  beat_t  mon_e;

  systolic_skew_feeder_if #(.SIZE(SIZE), .DATA_WIDTH(DW)) bus ();

  systolic_skew_feeder #(.SIZE(SIZE), .DATA_WIDTH(DW), .FLUSH_CYCLES(FLUSH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Undo the skew of the captured beats and multiply, as an output-stationary array would.
  task automatic check_c(input cmat_t exp);
    int bad_i, bad_j, acc, got_v, exp_v;
    bad_i = -1; bad_j = -1; got_v = 0; exp_v = 0;
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++) begin
        acc = 0;
        for (int k = 0; k < SIZE; k++)
          acc += int'($signed(a_hist[k+i][i*DW +: DW])) * int'($signed(b_hist[k+j][j*DW +: DW]));
        if (acc != int'($signed(exp[i][j])) && bad_i < 0) begin
          bad_i = i; bad_j = j; got_v = acc; exp_v = int'($signed(exp[i][j]));
        end
      end
    n_checks++;
    if (bad_i >= 0) begin
      n_fail++;
      $display("FAIL c_matrix: C[%0d][%0d] got %0d, expected %0d", bad_i, bad_j, got_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      bidx = 0;
    end else begin
      if (bus.busy && !bus.arr_rst_n) begin
        if (clr_q.size() == 0) chk("clear_unexpected", 1, 0);
        else chk("clear_cycle", cyc, clr_q.pop_front());
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk($sformatf("a_out_t%0d", bidx), bus.a_out, mon_e.a);
          chk($sformatf("b_out_t%0d", bidx), bus.b_out, mon_e.b);
        end
        if (bidx < BEATS) begin
          a_hist[bidx] = bus.a_out;
          b_hist[bidx] = bus.b_out;
        end
        bidx++;
      end
      if (bus.done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
        if (c_q.size() != 0) check_c(c_q.pop_front());
        bidx = 0;
      end
    end
  end

  function automatic vec_t col_of(input mat_t m, input int k);
    vec_t v;
    for (int i = 0; i < SIZE; i++) v[i*DW +: DW] = m[i][k];
    return v;
  endfunction

  function automatic vec_t row_of(input mat_t m, input int k);
    vec_t v;
    for (int j = 0; j < SIZE; j++) v[j*DW +: DW] = m[k][j];
    return v;
  endfunction

  function automatic vec_t skew_a(input mat_t m, input int t);
    vec_t v = '0;
    for (int i = 0; i < SIZE; i++)
      if (t - i >= 0 && t - i < int'(SIZE)) v[i*DW +: DW] = m[i][t-i];
    return v;
  endfunction

  function automatic vec_t skew_b(input mat_t m, input int t);
    vec_t v = '0;
    for (int j = 0; j < SIZE; j++)
      if (t - j >= 0 && t - j < int'(SIZE)) v[j*DW +: DW] = m[t-j][j];
    return v;
  endfunction

  // Drives SIZE beats (waiting on load_ready), then queues the job's expected response.
  task automatic load_job(input mat_t a, input mat_t b, input cmat_t cexp, output longint first_acc);
    longint c_last, start;
    int     waited;
    beat_t  e;
    first_acc = 0;
    c_last = 0;
    for (int k = 0; k < SIZE; k++) begin
      bus.load_valid = 1'b1;
      bus.load_a_col = col_of(a, k);
      bus.load_b_row = row_of(b, k);
      @(negedge clk);
      waited = 0;
      while (!bus.load_ready && waited < TIMEOUT) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.load_ready) begin
        chk("load_ready_timeout", 0, 1);
        bus.load_valid = 1'b0;
        return;
      end
      if (k == 0) first_acc = cyc;
      c_last = cyc;
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    start = (c_last > last_done) ? c_last : last_done;
    clr_q.push_back(start + 1);
    for (int t = 0; t < int'(BEATS); t++) begin
      e.a = skew_a(a, t);
      e.b = skew_b(b, t);
      exp_q.push_back(e);
    end
    last_done = start + JOB_LAT;
    done_q.push_back(last_done);
    c_q.push_back(cexp);
  endtask

  task automatic wait_jobs();
    int n = 0;
    while ((done_q.size() != 0 || exp_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk("jobs_drained", done_q.size() + exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_a_out"}, bus.a_out, 0);
    chk({tag, "_b_out"}, bus.b_out, 0);
    chk({tag, "_ctrl"}, {bus.out_valid, bus.busy, bus.done, bus.load_ready, bus.arr_rst_n}, 0);
  endtask

  mat_t   ma, mb;
  cmat_t  mc;
  longint acc1, acc2, d1;

  initial begin
    bus.load_valid = 1'b0;
    bus.load_a_col = '0;
    bus.load_b_row = '0;

    // Reset values, then idle after release.
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_load_ready", bus.load_ready, 1);
    chk("idle_arr_rst_n", bus.arr_rst_n, 1);
    chk("idle_busy", bus.busy, 0);

    // Identity A: C must equal B.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = (i == k) ? 8'd1 : 8'd0;
        mb[i][k] = DW'(i * 8 + k);
        mc[i][k] = 32'(i * 8 + k);
      end
    load_job(ma, mb, mc, acc1);
    wait_jobs();

    // Extreme signed operands pass through unchanged.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 8'h80;
        mb[i][k] = 8'h7F;
        mc[i][k] = 32'hFFFE_0400;
      end
    load_job(ma, mb, mc, acc1);
    wait_jobs();

    // load_valid held high across a job.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 8'd2;
        mb[i][k] = 8'd3;
        mc[i][k] = 32'd48;
      end
    load_job(ma, mb, mc, acc1);
    d1 = last_done;
`ifndef SKEW_FEEDER_DBUF_EN
    bus.load_valid = 1'b1;
    bus.load_a_col = {SIZE{8'hA5}};
    bus.load_b_row = {SIZE{8'h5A}};
    repeat (20) @(posedge clk);
    #1;
    chk("ready_low_while_busy", bus.load_ready, 0);
`else
    wait_jobs();
`endif
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = (i == k) ? 8'd1 : 8'd0;
        mb[i][k] = 8'hFF;
        mc[i][k] = 32'hFFFF_FFFF;
      end
    load_job(ma, mb, mc, acc2);
`ifndef SKEW_FEEDER_DBUF_EN
    chk("job2_first_accept", acc2, d1 + 1);
`endif
    wait_jobs();

    // Reset in the middle of STREAM (t=5), then a fresh job.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 8'd1;
        mb[i][k] = DW'(k - i);
        mc[i][k] = 32'(8 * k - 28);
      end
    load_job(ma, mb, mc, acc1);
    while (cyc < last_done - JOB_LAT + 7) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("midjob_reset");
    exp_q.delete();
    done_q.delete();
    clr_q.delete();
    c_q.delete();
    last_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = (i == k) ? 8'd2 : 8'd0;
        mb[i][k] = DW'(i + k);
        mc[i][k] = 32'(2 * (i + k));
      end
    load_job(ma, mb, mc, acc1);
    wait_jobs();

`ifdef SKEW_FEEDER_DBUF_EN
    // Second job loads while the first streams and starts right after its DONE.
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 8'd1;
        mb[i][k] = 8'd1;
        mc[i][k] = 32'd8;
      end
    load_job(ma, mb, mc, acc1);
    d1 = last_done;
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < SIZE; k++) begin
        ma[i][k] = 8'hFF;
        mb[i][k] = 8'd2;
        mc[i][k] = 32'hFFFF_FFF0;
      end
    load_job(ma, mb, mc, acc2);
    chk("dbuf_loaded_during_job1", (acc2 + SIZE <= d1) ? 1 : 0, 1);
    wait_jobs();
`endif

    chk("scoreboard_empty", exp_q.size() + done_q.size() + clr_q.size() + c_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
